// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and encodings for the PC fetch unit.
// Also carries the shared defines: `PC_PLUS4 / `NEW_PC (pc_src encodings) and `FETCH_NOP.
// Optional feature macro used by the top: FETCH_MISALIGN_CHECK_EN.

`ifndef PC_FETCH_UNIT_DEFINES
`define PC_FETCH_UNIT_DEFINES
`define PC_PLUS4  1'b0
`define NEW_PC    1'b1
`define FETCH_NOP 32'h0000_0013
`endif

package pc_fetch_unit_pkg;

  // One instruction-buffer entry: the word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundle for pc_fetch_unit: execute redirect, imem request/response, decode handoff.
// master: the fetch unit. slave: the surrounding environment (execute, imem, decode).
//   pc_src/new_pc          redirect from execute
//   imem_req_*/imem_addr   fetch request to imem
//   imem_resp_*            in-order response words from imem
//   inst_*                 buffered instruction stream to decode
//   misalign_fault         sticky misaligned-redirect flag

interface pc_fetch_unit_if;
  logic        pc_src;
  logic [31:0] new_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_fault;

  modport master (
    input  pc_src, new_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, misalign_fault
  );

  modport slave (
    output pc_src, new_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, misalign_fault
  );
endinterface

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, word} entries for decode.
// Ports: clk, rst (sync, active-high); push/push_data write; pop reads head;
//        flush empties the FIFO and beats push/pop; head is the oldest entry; count is occupancy.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.

module pc_fetch_unit_fetch_buffer
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0) && !flush;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still safe then.
  assign do_push = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: owns the architectural PC, issues sequential imem requests, queues returned
// words for decode and flushes everything in flight on an execute redirect.
// Ports: clk, rst (sync, active-high), bus (pc_fetch_unit_if.master).
// Optional: FETCH_MISALIGN_CHECK_EN -- a misaligned redirect target sets a sticky
// misalign_fault that blocks issue until rst. Without it, redirect targets are word-aligned
// by clearing new_pc[1:0] and misalign_fault is tied 0.

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic              clk,
  input logic              rst,
  pc_fetch_unit_if.master  bus
);

  localparam int unsigned BufCntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OutW    = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [OutW-1:0]    out_q, out_d;
  logic [OutW-1:0]    drop_q, drop_d;
  logic [BufCntW-1:0] buf_count;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;
  logic               redirect, req_valid, issue, push, pop, fault;
  logic [31:0]        load_pc;
  int                 avail;

  assign redirect = (bus.pc_src == `NEW_PC);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign load_pc = bus.new_pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect && (bus.new_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  assign load_pc = {bus.new_pc[31:2], 2'b00};
  assign fault   = 1'b0;
`endif

  // Free buffer slots not already promised to live (non-dropped) in-flight requests.
  assign avail = int'(BUF_DEPTH) - int'(buf_count) - (int'(out_q) - int'(drop_q));

  assign req_valid = !rst && !redirect && (avail > 0) && (out_q < OutW'(MAX_OUTSTANDING))
                     && !fault;
  assign issue     = req_valid && bus.imem_req_ready;
  assign push      = bus.imem_resp_valid && !redirect && (drop_q == '0);
  assign pop       = bus.inst_valid && bus.inst_ready && !redirect;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    if (redirect) begin
      pc_d      = load_pc;
      resp_pc_d = load_pc;
      // No issue this cycle; everything still owed by imem after this edge is stale.
      out_d     = out_q - OutW'(bus.imem_resp_valid);
      drop_d    = out_d;
    end else begin
      if (issue) pc_d = pc_plus4(pc_q);
      if (push)  resp_pc_d = pc_plus4(resp_pc_q);
      case ({issue, bus.imem_resp_valid})
        2'b10:   out_d = out_q + OutW'(1);
        2'b01:   out_d = out_q - OutW'(1);
        default: out_d = out_q;
      endcase
      if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - OutW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, data: bus.imem_resp_data};

  pc_fetch_unit_fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (buf_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (buf_count != '0);
  assign bus.inst           = bus.inst_valid ? head.data : 32'h0;
  assign bus.inst_pc        = bus.inst_valid ? head.pc : 32'h0;
  assign bus.misalign_fault = fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (RESET_PC=0, BUF_DEPTH=2, MAX_OUTSTANDING=2).
// A per-cycle vector table covers streaming, back-pressure and redirects; hand-written
// sequences cover PC wrap, a stalled request, misaligned redirect and mid-run reset.

module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .BUF_DEPTH       (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_src;
    logic [31:0] new_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_addr;
    logic        inst_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst_pc;
  } vec_t;

  localparam int NumVec = 22;
  vec_t vecs [NumVec];
  int   checks = 0;
  int   errors = 0;

  // Word the fake imem returns for a given address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic ps, input logic [31:0] np, input logic rr,
                              input logic rv, input logic [31:0] ra, input logic ir,
                              input logic erv, input logic [31:0] ea, input logic eiv,
                              input logic [31:0] eipc);
    vec_t v;
    v.pc_src = ps; v.new_pc = np; v.req_ready = rr; v.resp_valid = rv; v.resp_addr = ra;
    v.inst_ready = ir; v.exp_req_valid = erv; v.exp_addr = ea; v.exp_inst_valid = eiv;
    v.exp_inst_pc = eipc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ps, input logic [31:0] np, input logic rr, input logic rv,
                       input logic [31:0] ra, input logic ir);
    bus.pc_src          = ps;
    bus.new_pc          = np;
    bus.imem_req_ready  = rr;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? word_at(ra) : 32'h0;
    bus.inst_ready      = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic P, N;
    P = `PC_PLUS4;
    N = `NEW_PC;

    // Streaming with 1-cycle imem latency, then back-pressure, then redirects.
    vecs[0]  = mk(P, 32'h0,   1, 0, 32'h0,   1,  1, 32'h000, 0, 32'h0);
    vecs[1]  = mk(P, 32'h0,   1, 1, 32'h000, 1,  1, 32'h004, 0, 32'h0);
    vecs[2]  = mk(P, 32'h0,   1, 1, 32'h004, 1,  0, 32'h008, 1, 32'h000);
    vecs[3]  = mk(P, 32'h0,   1, 0, 32'h0,   1,  1, 32'h008, 1, 32'h004);
    vecs[4]  = mk(P, 32'h0,   1, 1, 32'h008, 1,  1, 32'h00C, 0, 32'h0);
    vecs[5]  = mk(P, 32'h0,   1, 1, 32'h00C, 1,  0, 32'h010, 1, 32'h008);
    vecs[6]  = mk(P, 32'h0,   1, 0, 32'h0,   0,  1, 32'h010, 1, 32'h00C);
    vecs[7]  = mk(P, 32'h0,   1, 1, 32'h010, 0,  0, 32'h014, 1, 32'h00C);
    vecs[8]  = mk(P, 32'h0,   1, 0, 32'h0,   0,  0, 32'h014, 1, 32'h00C);
    vecs[9]  = mk(P, 32'h0,   1, 0, 32'h0,   0,  0, 32'h014, 1, 32'h00C);
    vecs[10] = mk(P, 32'h0,   1, 0, 32'h0,   1,  0, 32'h014, 1, 32'h00C);
    vecs[11] = mk(P, 32'h0,   1, 0, 32'h0,   1,  1, 32'h014, 1, 32'h010);
    vecs[12] = mk(P, 32'h0,   1, 0, 32'h0,   1,  1, 32'h018, 0, 32'h0);
    vecs[13] = mk(N, 32'h100, 1, 0, 32'h0,   1,  0, 32'h01C, 0, 32'h0);
    vecs[14] = mk(P, 32'h0,   1, 1, 32'h014, 1,  0, 32'h100, 0, 32'h0);
    vecs[15] = mk(P, 32'h0,   1, 1, 32'h018, 1,  1, 32'h100, 0, 32'h0);
    vecs[16] = mk(P, 32'h0,   1, 1, 32'h100, 1,  1, 32'h104, 0, 32'h0);
    vecs[17] = mk(N, 32'h200, 1, 1, 32'h104, 1,  0, 32'h108, 1, 32'h100);
    vecs[18] = mk(P, 32'h0,   1, 0, 32'h0,   1,  1, 32'h200, 0, 32'h0);
    vecs[19] = mk(P, 32'h0,   1, 1, 32'h200, 1,  1, 32'h204, 0, 32'h0);
    vecs[20] = mk(P, 32'h0,   1, 1, 32'h204, 1,  0, 32'h208, 1, 32'h200);
    vecs[21] = mk(P, 32'h0,   0, 0, 32'h0,   1,  1, 32'h208, 1, 32'h204);

    // Reset for 3 cycles.
    rst = 1'b1;
    drive(P, 32'h0, 1, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #3;
      check($sformatf("rst%0d.req_valid", i), 32'(bus.imem_req_valid), 32'h0);
      check($sformatf("rst%0d.inst_valid", i), 32'(bus.inst_valid), 32'h0);
      check($sformatf("rst%0d.inst", i), bus.inst, 32'h0);
      check($sformatf("rst%0d.inst_pc", i), bus.inst_pc, 32'h0);
      check($sformatf("rst%0d.fault", i), 32'(bus.misalign_fault), 32'h0);
      check($sformatf("rst%0d.addr", i), bus.imem_addr, 32'h0);
    end
    tick();
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].pc_src, vecs[i].new_pc, vecs[i].req_ready, vecs[i].resp_valid,
            vecs[i].resp_addr, vecs[i].inst_ready);
      #3;
      check($sformatf("v%0d.req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_req_valid));
      check($sformatf("v%0d.addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d.inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].exp_inst_valid));
      if (vecs[i].exp_inst_valid) begin
        check($sformatf("v%0d.inst_pc", i), bus.inst_pc, vecs[i].exp_inst_pc);
        check($sformatf("v%0d.inst", i), bus.inst, word_at(vecs[i].exp_inst_pc));
      end
      tick();
    end

    // PC wrap at 0xFFFF_FFFC, then a stalled request must hold its address.
    drive(N, 32'hFFFF_FFFC, 1, 0, 32'h0, 1);
    #3;
    check("wrap.redirect_blocks_issue", 32'(bus.imem_req_valid), 32'h0);
    tick();
    drive(P, 32'h0, 1, 0, 32'h0, 0);
    #3;
    check("wrap.addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap.req_valid_top", 32'(bus.imem_req_valid), 32'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(P, 32'h0, 0, k == 0, 32'hFFFF_FFFC, 0);
      #3;
      check($sformatf("stall%0d.addr", k), bus.imem_addr, 32'h0000_0000);
      check($sformatf("stall%0d.req_valid", k), 32'(bus.imem_req_valid), 32'h1);
      tick();
    end
    drive(P, 32'h0, 1, 0, 32'h0, 0);
    #3;
    check("wrap.inst_valid", 32'(bus.inst_valid), 32'h1);
    check("wrap.inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    check("wrap.inst", bus.inst, word_at(32'hFFFF_FFFC));
    tick();

    // Misaligned redirect with a same-cycle response for addr 0.
    drive(N, 32'h102, 1, 1, 32'h0, 0);
    #3;
    check("mis.redirect_blocks_issue", 32'(bus.imem_req_valid), 32'h0);
    tick();
    drive(P, 32'h0, 1, 0, 32'h0, 1);
    #3;
    check("mis.inst_valid", 32'(bus.inst_valid), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis.fault", 32'(bus.misalign_fault), 32'h1);
    check("mis.addr", bus.imem_addr, 32'h102);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mis%0d.req_blocked", k), 32'(bus.imem_req_valid), 32'h0);
      tick();
      #3;
    end
    check("mis.fault_sticky", 32'(bus.misalign_fault), 32'h1);
    tick();
`else
    check("mis.fault", 32'(bus.misalign_fault), 32'h0);
    check("mis.addr", bus.imem_addr, 32'h100);
    check("mis.req_valid", 32'(bus.imem_req_valid), 32'h1);
    tick();
    drive(P, 32'h0, 1, 1, 32'h100, 1);
    #3;
    check("mis.addr_next", bus.imem_addr, 32'h104);
    tick();
    drive(P, 32'h0, 0, 0, 32'h0, 0);
    #3;
    check("mis.inst_pc", bus.inst_pc, 32'h100);
    check("mis.inst", bus.inst, word_at(32'h100));
    tick();
`endif

    // Reset mid-operation beats a simultaneous redirect.
    rst = 1'b1;
    drive(N, 32'h300, 1, 0, 32'h0, 1);
    #3;
    check("rst_mid.req_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    #3;
    check("rst_mid.addr", bus.imem_addr, 32'h0);
    check("rst_mid.inst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_mid.fault", 32'(bus.misalign_fault), 32'h0);
    tick();
    rst = 1'b0;
    drive(P, 32'h0, 1, 0, 32'h0, 1);
    #3;
    check("rst_mid.req_after", 32'(bus.imem_req_valid), 32'h1);
    check("rst_mid.addr_after", bus.imem_addr, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
